// File: rtl/hub75_row_shifter.sv
// HUB75 row shifter: fetches one row per segment from the framebuffer,
// extracts a bit-plane and clocks it onto the panel RGB/SCLK pins.
module hub75_row_shifter #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p = 8,
  parameter int segments_p = 2,
  parameter int clk_div_wd_p = 8,
  localparam int frame_size_p = hpixel_p * vpixel_p,
  localparam int addr_width_p = $clog2(frame_size_p),
  localparam int pix_bit_width_p = $clog2(bpp_p),
  localparam int seg_offset_p = frame_size_p / segments_p
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [clk_div_wd_p-1:0]    i_clk_div,
  input  logic                       i_tx_start,
  input  logic [addr_width_p-1:0]    i_init_addr,
  input  logic [pix_bit_width_p-1:0] i_pix_bit,
  output logic                       o_tx_ready,
  output logic                       o_mem_rd_en,
  output logic [addr_width_p-1:0]    o_mem_addr,
  input  logic [3*bpp_p-1:0]         i_mem_rdata,
  output logic [3*segments_p-1:0]    o_rgb,
  output logic                       o_sclk
);

  localparam int col_wd_l = $clog2(hpixel_p);
  localparam int k_wd_l = $clog2(segments_p + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CLK_LO,
    CLK_HI
  } state_t;

  state_t state_q, state_d;

  logic [addr_width_p-1:0]    init_q;
  logic [addr_width_p-1:0]    addr_q;
  logic [addr_width_p-1:0]    addr_calc;
  logic [pix_bit_width_p-1:0] pb_q;
  logic [clk_div_wd_p-1:0]    div_q;
  logic [clk_div_wd_p-1:0]    ph_q;
  logic [col_wd_l-1:0]        col_q;
  logic [k_wd_l-1:0]          k_q;
  logic [3*segments_p-1:0]    stage_q;
  logic [3*segments_p-1:0]    stage_d;
  logic [bpp_p-1:0]           r_w;
  logic [bpp_p-1:0]           g_w;
  logic [bpp_p-1:0]           b_w;
  logic [2:0]                 bits;
  logic                       issue;
  logic                       ph_end;
  logic                       last_col;
  logic                       start;

  assign r_w = i_mem_rdata[3*bpp_p-1:2*bpp_p];
  assign g_w = i_mem_rdata[2*bpp_p-1:bpp_p];
  assign b_w = i_mem_rdata[bpp_p-1:0];
  assign bits = {r_w[pb_q], g_w[pb_q], b_w[pb_q]};

  assign addr_calc = init_q
                   + addr_width_p'(col_q)
                   + addr_width_p'(int'(k_q) * seg_offset_p);

  assign ph_end = (ph_q == div_q);
  assign last_col = (col_q == col_wd_l'(hpixel_p - 1));
  assign start = (state_q == IDLE) && i_tx_start;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_tx_start) state_d = FETCH;
      end
      FETCH: begin
        issue = (k_q < k_wd_l'(segments_p));
        // data for the read issued at k-1 lands now
        for (int s = 0; s < segments_p; s++) begin
          if (k_q == k_wd_l'(s + 1)) stage_d[3*s +: 3] = bits;
        end
        if (k_q == k_wd_l'(segments_p)) state_d = CLK_LO;
      end
      CLK_LO: begin
        if (ph_end) state_d = CLK_HI;
      end
      CLK_HI: begin
        if (ph_end) state_d = last_col ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx_ready = (state_q == IDLE);
  assign o_sclk = (state_q == CLK_HI);
  assign o_mem_rd_en = issue;
  assign o_mem_addr = issue ? addr_calc : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      init_q <= '0;
      addr_q <= '0;
      pb_q <= '0;
      div_q <= '0;
      ph_q <= '0;
      col_q <= '0;
      k_q <= '0;
      stage_q <= '0;
      o_rgb <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      addr_q <= o_mem_addr;
      if (start) begin
        init_q <= i_init_addr;
        pb_q <= i_pix_bit;
        div_q <= i_clk_div;
        col_q <= '0;
        k_q <= '0;
        ph_q <= '0;
      end
      if (state_q == FETCH) k_q <= k_q + 1'b1;
      if (state_q == FETCH && state_d == CLK_LO) o_rgb <= stage_d;
      if (state_q == CLK_LO || state_q == CLK_HI) begin
        ph_q <= ph_end ? '0 : ph_q + 1'b1;
      end
      if (state_q == CLK_HI && ph_end && !last_col) begin
        col_q <= col_q + 1'b1;
        k_q <= '0;
      end
    end
  end

endmodule
